// File: rtl/yarp_fetch_pkg.sv
// Shared types and constants for the yarp fetch queue.
// YARP_FETCH_ERR_EN adds a per-entry fetch error bit.
package yarp_fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef YARP_FETCH_ERR_EN
    logic        err;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/yarp_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; head reads as zero when empty.
// Entry layout follows YARP_FETCH_ERR_EN through the package type.
module yarp_fetch_fifo
  import yarp_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: nothing is read until a push has landed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/yarp_fetch_queue.sv
// Prefetching instruction-fetch front end: PC, credit and drop tracking around a FIFO.
// Define YARP_FETCH_ERR_EN for per-instruction fetch error reporting.
module yarp_fetch_queue
  import yarp_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_d_cache_busy_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_mem_req_o,
  output logic [31:0] instr_mem_addr_o,
  input  logic        instr_mem_gnt_i,
  input  logic        mem_rd_valid_i,
  input  logic [31:0] mem_rd_data_i,
`ifdef YARP_FETCH_ERR_EN
  input  logic        mem_rd_err_i,
  output logic        instr_err_o,
`endif
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc, resp_pc, new_pc;
  logic [CW-1:0] outstanding, drop_cnt, count, outs_nxt;
  logic          credit_ok, accept, drop, push, pop, empty, fifo_full, halt;
  fetch_entry_t  push_entry, head;

  assign new_pc = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef YARP_FETCH_ERR_EN
  logic err_push;
  assign err_push = push & mem_rd_err_i;
`else
  logic err_push;
  assign err_push = 1'b0;
`endif

  always_comb begin
    credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    instr_mem_req_o = !reset && !fetch_d_cache_busy_i && !redirect_i && credit_ok && !halt;
    accept          = instr_mem_req_o && instr_mem_gnt_i;
    outs_nxt        = outstanding + CW'(accept) - CW'(mem_rd_valid_i);
    drop            = mem_rd_valid_i && (drop_cnt != '0);
    push            = mem_rd_valid_i && !drop && !redirect_i;
    instr_valid_o   = !empty && !redirect_i;
    pop             = instr_valid_o && instr_ready_i;
    push_entry       = '0;
    push_entry.pc    = resp_pc;
    push_entry.instr = mem_rd_data_i;
`ifdef YARP_FETCH_ERR_EN
    push_entry.err   = mem_rd_err_i;
`endif
  end

  assign instr_mem_addr_o = fetch_pc;
  assign instr_pc_o       = head.pc;
  assign instr_o          = head.instr;
`ifdef YARP_FETCH_ERR_EN
  assign instr_err_o      = head.err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halt        <= 1'b0;
    end else if (redirect_i) begin
      // Everything still in flight, including this cycle's response, is dropped.
      fetch_pc    <= new_pc;
      resp_pc     <= new_pc;
      outstanding <= outs_nxt;
      drop_cnt    <= outs_nxt;
      halt        <= 1'b0;
    end else begin
      outstanding <= outs_nxt;
      if (accept)   fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      if (drop)     drop_cnt <= drop_cnt - 1'b1;
      if (push)     resp_pc  <= resp_pc + 32'(INSTR_BYTES);
      if (err_push) halt     <= 1'b1;
    end
  end

  yarp_fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (fifo_full)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full))
    else $error("fetch fifo push while full");

endmodule
